// File: rtl/mem_io_responder_if.sv
// ----------------------------------------------------------------------------
// mem_io_responder_if
//
// Purpose:
//   Bundles the CPU memory handshake (MIO_EN/R_W request, MEM_R ready), the
//   MAR/MDR data paths and the off-chip SRAM pins into one interface. The
//   responder connects through the 'slave' modport. The environment (CPU
//   datapath, SRAM device and board switches) connects through 'master'.
//
// Signals:
//   MIO_EN      request, active-low            (master -> slave)
//   R_W         1 = read, 0 = write            (master -> slave)
//   ADDR        access address (MAR)           (master -> slave)
//   Data_CPU    write data (MDR)               (master -> slave)
//   Data_Mem    read data register             (slave -> master)
//   MEM_R       one-cycle ready pulse          (slave -> master)
//   SRAM_ADDR   20-bit SRAM address            (slave -> master)
//   SRAM_DQ_I   SRAM read data                 (master -> slave)
//   SRAM_DQ_O   SRAM write data                (slave -> master)
//   SRAM_CE_N   chip enable, active-low        (slave -> master)
//   SRAM_OE_N   output enable, active-low      (slave -> master)
//   SRAM_WE_N   write enable, active-low       (slave -> master)
//   Switches    board switches                 (master -> slave, MMIO build)
//   Hex_Out     hex display register           (slave -> master, MMIO build)
//
// Configuration macro: MEM_IO_RESP_MMIO_EN adds the Switches/Hex_Out signals.
// ----------------------------------------------------------------------------
interface mem_io_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              MIO_EN;
    logic              R_W;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] Data_CPU;
    logic [DATA_W-1:0] Data_Mem;
    logic              MEM_R;

    logic [19:0]       SRAM_ADDR;
    logic [DATA_W-1:0] SRAM_DQ_I;
    logic [DATA_W-1:0] SRAM_DQ_O;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;
    logic              SRAM_WE_N;

`ifdef MEM_IO_RESP_MMIO_EN
    logic [DATA_W-1:0] Switches;
    logic [DATA_W-1:0] Hex_Out;

    modport slave (
        input  MIO_EN, R_W, ADDR, Data_CPU, SRAM_DQ_I, Switches,
        output Data_Mem, MEM_R, SRAM_ADDR, SRAM_DQ_O,
               SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, Hex_Out
    );

    modport master (
        output MIO_EN, R_W, ADDR, Data_CPU, SRAM_DQ_I, Switches,
        input  Data_Mem, MEM_R, SRAM_ADDR, SRAM_DQ_O,
               SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, Hex_Out
    );
`else
    modport slave (
        input  MIO_EN, R_W, ADDR, Data_CPU, SRAM_DQ_I,
        output Data_Mem, MEM_R, SRAM_ADDR, SRAM_DQ_O,
               SRAM_CE_N, SRAM_OE_N, SRAM_WE_N
    );

    modport master (
        output MIO_EN, R_W, ADDR, Data_CPU, SRAM_DQ_I,
        input  Data_Mem, MEM_R, SRAM_ADDR, SRAM_DQ_O,
               SRAM_CE_N, SRAM_OE_N, SRAM_WE_N
    );
`endif
endinterface

// File: rtl/mem_io_responder.sv
// ----------------------------------------------------------------------------
// mem_io_responder
//
// Purpose:
//   Memory-side responder for the CPU's MIO_EN/R_W handshake. It accepts one
//   read or write at a time and holds the SRAM strobes for WAIT_CYCLES cycles.
//   It then captures read data into Data_Mem and pulses MEM_R for one cycle.
//   FSM: IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE (MEM_R) -> IDLE.
//
// Parameters:
//   WAIT_CYCLES  strobe cycles per access, 1..15
//   ADDR_W       CPU address width (must not exceed 20)
//   DATA_W       data width
//   IO_ADDR      memory-mapped I/O address (MMIO build only)
//
// Ports:
//   Clk    in   system clock, rising edge
//   Reset  in   asynchronous reset, active-low
//   bus    mem_io_responder_if.slave: CPU handshake, data and SRAM pins
//
// Configuration macro: MEM_IO_RESP_MMIO_EN
//   Defined  : an access whose latched address equals IO_ADDR targets the board
//              I/O instead of SRAM. Reads return Switches and writes load
//              Hex_Out. No SRAM strobe is asserted, and latency is unchanged.
//   Undefined: every address goes to SRAM; the Switches/Hex_Out signals are absent.
// ----------------------------------------------------------------------------
module mem_io_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
`ifdef MEM_IO_RESP_MMIO_EN
    ,
    parameter logic [ADDR_W-1:0] IO_ADDR = 16'hFFFF
`endif
) (
    input  logic                  Clk,
    input  logic                  Reset,
    mem_io_responder_if.slave     bus
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("mem_io_responder: WAIT_CYCLES must be in 1..15");
        end
        if (ADDR_W < 1 || ADDR_W > 20) begin : g_bad_addr_w
            $error("mem_io_responder: ADDR_W must be in 1..20");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // The counter holds the remaining ACCESS cycles minus one. Loading
    // WAIT_CYCLES-1 gives exactly WAIT_CYCLES strobe cycles.
    localparam logic [3:0] CNT_LOAD  = 4'(WAIT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [3:0]        count_q, count_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef MEM_IO_RESP_MMIO_EN
    logic              io_q, io_d;
    logic [DATA_W-1:0] hex_q, hex_d;
`endif

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    logic              in_access;
    logic              last_access;
    logic              sram_sel;
    logic [DATA_W-1:0] read_src;

    assign in_access   = (state_q == ST_ACCESS);
    assign last_access = in_access && (count_q == 4'd0);

`ifdef MEM_IO_RESP_MMIO_EN
    // The I/O decision is latched with the request. A later change to ADDR
    // therefore cannot move an access between SRAM and I/O mid-strobe.
    assign sram_sel = ~io_q;
    assign read_src = io_q ? bus.Switches : bus.SRAM_DQ_I;
`else
    assign sram_sel = 1'b1;
    assign read_src = bus.SRAM_DQ_I;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MEM_IO_RESP_MMIO_EN
        io_d    = io_q;
        hex_d   = hex_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Request inputs are sampled only here. Changes to them
                // during ACCESS/DONE never reach the latched copies.
                if (!bus.MIO_EN) begin
                    state_d = ST_ACCESS;
                    count_d = CNT_LOAD;
                    rw_d    = bus.R_W;
                    addr_d  = bus.ADDR;
                    wdata_d = bus.Data_CPU;
`ifdef MEM_IO_RESP_MMIO_EN
                    io_d    = (bus.ADDR == IO_ADDR);
`endif
                end
            end

            ST_ACCESS: begin
                if (count_q == 4'd0) begin
                    state_d = ST_DONE;
                    // Only a completed read updates Data_Mem. Writes leave
                    // the last read value in place.
                    if (rw_q) begin
                        rdata_d = read_src;
                    end
`ifdef MEM_IO_RESP_MMIO_EN
                    if (!rw_q && io_q) begin
                        hex_d = wdata_q;
                    end
`endif
                end else begin
                    count_d = count_q - 4'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            count_q <= 4'd0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_IO_RESP_MMIO_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            io_q  <= 1'b0;
            hex_q <= '0;
        end else begin
            io_q  <= io_d;
            hex_q <= hex_d;
        end
    end

    assign bus.Hex_Out = hex_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The strobes decode directly from registered state. Reset forces them
    // high at once, and WE_N rises on the same edge that enters DONE. The
    // latched address and data therefore stay stable for the whole strobe.
    assign bus.SRAM_CE_N = ~(in_access && sram_sel);
    assign bus.SRAM_OE_N = ~(in_access && sram_sel && rw_q);
    assign bus.SRAM_WE_N = ~(in_access && sram_sel && !rw_q);

    assign bus.MEM_R     = (state_q == ST_DONE);
    assign bus.Data_Mem  = rdata_q;
    assign bus.SRAM_DQ_O = wdata_q;

    // Zero-extend the latched CPU address onto the 20-bit SRAM address bus.
    genvar gi;
    generate
        for (gi = 0; gi < 20; gi++) begin : g_sram_addr
            if (gi < ADDR_W) begin : g_bit
                assign bus.SRAM_ADDR[gi] = addr_q[gi];
            end else begin : g_pad
                assign bus.SRAM_ADDR[gi] = 1'b0;
            end
        end
    endgenerate

    // last_access is kept as a named term for debug visibility. The
    // reduction below consumes it without affecting any output.
    logic unused_ok;
    assign unused_ok = &{1'b0, last_access};

endmodule

// File: tb/tb_mem_io_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_io_responder
//
// Purpose:
//   Self-checking bench for mem_io_responder with WAIT_CYCLES=2. The stimulus
//   table of {request, expected Data_Mem} records feeds a scoreboard queue,
//   and a simple SRAM model services the strobes. Hand-written sequences
//   cover reset values, back-to-back requests and reset during an access.
//   With MEM_IO_RESP_MMIO_EN defined, further sequences cover the I/O path.
// ----------------------------------------------------------------------------
module tb_mem_io_responder;

    localparam int W = 2;

    logic Clk;
    logic Reset;

    mem_io_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_io_responder #(
        .WAIT_CYCLES (W),
        .ADDR_W      (16),
        .DATA_W      (16)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ------------------------------------------------------------------
    // SRAM model: a write happens on any rising edge that sees CE_N and
    // WE_N low. Read data is driven only while CE_N and OE_N are low.
    // ------------------------------------------------------------------
    logic [15:0] sram_mem [0:65535];

    always @(posedge Clk) begin
        if (bus.SRAM_CE_N == 1'b0 && bus.SRAM_WE_N == 1'b0) begin
            sram_mem[bus.SRAM_ADDR[15:0]] <= bus.SRAM_DQ_O;
        end
    end

    always_comb begin
        bus.SRAM_DQ_I = 16'hXXXX;
        if (bus.SRAM_CE_N == 1'b0 && bus.SRAM_OE_N == 1'b0) begin
            bus.SRAM_DQ_I = sram_mem[bus.SRAM_ADDR[15:0]];
        end
    end

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        perturb;   // scramble request inputs during ACCESS
        logic [15:0] exp_dm;    // Data_Mem expected at MEM_R
    } vec_t;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_dm;
    } sb_t;

    sb_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request from the IDLE state, follow it to MEM_R and check it.
    // Call at a negedge with the DUT idle; returns at a negedge in IDLE.
    task automatic do_txn(input int idx, input vec_t v);
        sb_t  e;
        int   cyc;
        int   ce_cnt;
        int   oe_cnt;
        int   we_cnt;
        bit   got;
        logic is_io;

        is_io = 1'b0;
`ifdef MEM_IO_RESP_MMIO_EN
        is_io = (v.addr == 16'hFFFF);
`endif
        bus.MIO_EN   = 1'b0;
        bus.R_W      = v.rw;
        bus.ADDR     = v.addr;
        bus.Data_CPU = v.wdata;
        sb_q.push_back('{v.rw, v.addr, v.wdata, v.exp_dm});

        @(negedge Clk);            // request edge has passed
        bus.MIO_EN = 1'b1;
        if (v.perturb) begin
            bus.Data_CPU = 16'hFFFF;
            bus.ADDR     = ~v.addr;
            bus.R_W      = ~v.rw;
        end

        cyc    = 1;
        ce_cnt = 0;
        oe_cnt = 0;
        we_cnt = 0;
        got    = 1'b0;
        while (!got && cyc <= 20) begin
            if (bus.SRAM_CE_N === 1'b0) begin
                ce_cnt++;
                chk("sram_addr", {12'h0, bus.SRAM_ADDR}, {16'h0, 4'h0, v.addr});
            end
            if (bus.SRAM_OE_N === 1'b0) oe_cnt++;
            if (bus.SRAM_WE_N === 1'b0) begin
                we_cnt++;
                chk("sram_dq_o", {16'h0, bus.SRAM_DQ_O}, {16'h0, v.wdata});
            end
            if (bus.MEM_R === 1'b1) begin
                got = 1'b1;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL scoreboard: got MEM_R expected no pending request");
                end else begin
                    e = sb_q.pop_front();
                    chk("latency", cyc, W + 1);
                    chk("data_mem", {16'h0, bus.Data_Mem}, {16'h0, e.exp_dm});
                    chk("ce_cycles", ce_cnt, is_io ? 0 : W);
                    if (!is_io) begin
                        chk("oe_cycles", oe_cnt, e.rw ? W : 0);
                        chk("we_cycles", we_cnt, e.rw ? 0 : W);
                    end
`ifdef MEM_IO_RESP_MMIO_EN
                    if (is_io && !e.rw) begin
                        chk("hex_out", {16'h0, bus.Hex_Out}, {16'h0, e.wdata});
                    end
`endif
                end
            end else begin
                @(negedge Clk);
                cyc++;
            end
        end

        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: got no MEM_R in 20 cycles expected MEM_R at cycle %0d", W + 1);
            sb_q.delete();
        end else begin
            @(negedge Clk);
            chk("mem_r_pulse", {31'h0, bus.MEM_R}, 32'h0);
        end
        $display("TXN %0d %s addr=%h wdata=%h data_mem=%h exp=%h latency=%0d ce=%0d oe=%0d we=%0d",
                 idx, v.rw ? "RD" : "WR", v.addr, v.wdata, bus.Data_Mem, v.exp_dm,
                 cyc, ce_cnt, oe_cnt, we_cnt);
    endtask

    // ------------------------------------------------------------------
    // Global watchdog
    // ------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    vec_t vecs [9];
    int   pulse_pos [$];
    int   mem_r_seen;
    int   ce_seen;

    initial begin
        vecs[0] = '{1'b0, 16'h3000, 16'hBEEF, 1'b0, 16'h0000};
        vecs[1] = '{1'b1, 16'h3000, 16'h0000, 1'b0, 16'hBEEF};
        vecs[2] = '{1'b0, 16'h0040, 16'h1234, 1'b1, 16'hBEEF};
        vecs[3] = '{1'b1, 16'h0040, 16'h0000, 1'b0, 16'h1234};
        vecs[4] = '{1'b0, 16'h0041, 16'hA5A5, 1'b0, 16'h1234};
        vecs[5] = '{1'b1, 16'h0041, 16'h0000, 1'b1, 16'hA5A5};
        vecs[6] = '{1'b1, 16'h3000, 16'h0000, 1'b0, 16'hBEEF};
        vecs[7] = '{1'b0, 16'h0040, 16'h5555, 1'b0, 16'hBEEF};
        vecs[8] = '{1'b1, 16'h0040, 16'h0000, 1'b0, 16'h5555};

        Reset        = 1'b0;
        bus.MIO_EN   = 1'b1;
        bus.R_W      = 1'b1;
        bus.ADDR     = 16'h0000;
        bus.Data_CPU = 16'h0000;
`ifdef MEM_IO_RESP_MMIO_EN
        bus.Switches = 16'h0000;
`endif

        // Reset state
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_ce_n",   {31'h0, bus.SRAM_CE_N}, 32'h1);
        chk("rst_oe_n",   {31'h0, bus.SRAM_OE_N}, 32'h1);
        chk("rst_we_n",   {31'h0, bus.SRAM_WE_N}, 32'h1);
        chk("rst_mem_r",  {31'h0, bus.MEM_R}, 32'h0);
        chk("rst_data",   {16'h0, bus.Data_Mem}, 32'h0);
        chk("rst_addr",   {12'h0, bus.SRAM_ADDR}, 32'h0);
        chk("rst_dq_o",   {16'h0, bus.SRAM_DQ_O}, 32'h0);
`ifdef MEM_IO_RESP_MMIO_EN
        chk("rst_hex",    {16'h0, bus.Hex_Out}, 32'h0);
`endif
        Reset = 1'b1;
        @(negedge Clk);

        // Table-driven transactions
        for (int i = 0; i < 9; i++) begin
            do_txn(i, vecs[i]);
        end

        // MIO_EN held low for 12 cycles: reads back to back
        bus.MIO_EN = 1'b0;
        bus.R_W    = 1'b1;
        bus.ADDR   = 16'h0040;
        pulse_pos.delete();
        for (int k = 1; k <= 18; k++) begin
            @(negedge Clk);
            if (bus.MEM_R === 1'b1) begin
                pulse_pos.push_back(k);
                chk("b2b_data", {16'h0, bus.Data_Mem}, 32'h5555);
            end
            if (k == 12) bus.MIO_EN = 1'b1;
        end
        $display("TXN b2b pulses=%0d", pulse_pos.size());
        chk("b2b_count", pulse_pos.size(), 3);
        if (pulse_pos.size() == 3) begin
            chk("b2b_first",  pulse_pos[0], W + 1);
            chk("b2b_space1", pulse_pos[1] - pulse_pos[0], W + 2);
            chk("b2b_space2", pulse_pos[2] - pulse_pos[1], W + 2);
        end

        // Reset asserted mid-ACCESS on a write
        bus.MIO_EN   = 1'b0;
        bus.R_W      = 1'b0;
        bus.ADDR     = 16'h0050;
        bus.Data_CPU = 16'h7777;
        @(negedge Clk);
        bus.MIO_EN = 1'b1;
        chk("abort_we_active", {31'h0, bus.SRAM_WE_N}, 32'h0);
        Reset = 1'b0;
        #1;
        chk("abort_ce_n",  {31'h0, bus.SRAM_CE_N}, 32'h1);
        chk("abort_we_n",  {31'h0, bus.SRAM_WE_N}, 32'h1);
        chk("abort_oe_n",  {31'h0, bus.SRAM_OE_N}, 32'h1);
        chk("abort_mem_r", {31'h0, bus.MEM_R}, 32'h0);
        chk("abort_data",  {16'h0, bus.Data_Mem}, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        mem_r_seen = 0;
        ce_seen    = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (bus.MEM_R === 1'b1) mem_r_seen++;
            if (bus.SRAM_CE_N === 1'b0) ce_seen++;
        end
        $display("TXN abort mem_r=%0d ce=%0d", mem_r_seen, ce_seen);
        chk("abort_no_mem_r", mem_r_seen, 0);
        chk("abort_idle",     ce_seen, 0);

`ifdef MEM_IO_RESP_MMIO_EN
        // Memory-mapped I/O
        bus.Switches = 16'h0F0F;
        do_txn(100, '{1'b0, 16'hFFFF, 16'h00A5, 1'b0, 16'h0000});
        do_txn(101, '{1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h0F0F});
        chk("mmio_hex_hold", {16'h0, bus.Hex_Out}, 32'h00A5);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
